// File: rtl/pwm_compare_deadtime.sv
// pwm_compare_deadtime: carrier compare with valley-shadowed duty and dead-time gate pair
// Ports:
//   clk, rst (async, active-low)
//   carrier      triangular carrier count
//   duty         duty reference, accepted on duty_valid & duty_ready
//   duty_valid   duty strobe; duty_ready is high while the pending slot is empty
//   dead_time    dead interval in clocks, sampled on entry to DEAD
//   enable       0 forces both gates low
//   pwm_hi       high-side gate
//   pwm_lo       low-side gate
//   duty_active  duty value the comparator is using
module pwm_compare_deadtime #(
    parameter int WIDTH_TRIANG = 6,
    parameter int DEAD_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH_TRIANG-1:0] carrier,
    input  logic [WIDTH_TRIANG-1:0] duty,
    input  logic                    duty_valid,
    output logic                    duty_ready,
    input  logic [DEAD_WIDTH-1:0]   dead_time,
    input  logic                    enable,
    output logic                    pwm_hi,
    output logic                    pwm_lo,
    output logic [WIDTH_TRIANG-1:0] duty_active
);
    typedef enum logic [1:0] {OFF, DEAD, HI, LO} state_t;
    state_t                  state_q, state_d;
    logic [WIDTH_TRIANG-1:0] pend_q, pend_d, act_q, act_d;
    logic                    full_q, full_d, raw_q, raw_d, tgt_q, tgt_d;
    logic [DEAD_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    valley, accept, dt_zero, enter;
    assign valley      = carrier == '0;
    assign accept      = duty_valid & ~full_q;
    assign dt_zero     = dead_time == '0;
    assign duty_ready  = ~full_q;
    assign duty_active = act_q;
    assign pwm_hi      = state_q == HI;
    assign pwm_lo      = state_q == LO;
    // Accept only into an empty slot, so a valley transfer and an accept never collide;
    // a duty accepted on a valley waits for the next one.
    always_comb begin
        pend_d = accept ? duty : pend_q;
        full_d = accept | (full_q & ~valley);
        act_d  = (valley & full_q) ? pend_q : act_q;
        raw_d  = enable & (carrier < act_q);
    end
    // Every change of raw_q outside DEAD (and a raw_q reversal inside DEAD) starts a
    // fresh dead interval aimed at raw_q; with zero dead time the side switches directly.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        enter   = 1'b0;
        if (!enable) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF:     enter = 1'b1;
                HI:      enter = ~raw_q;
                LO:      enter = raw_q;
                default: begin
                    if (raw_q != tgt_q) enter = 1'b1;
                    else if (cnt_q == '0) state_d = tgt_q ? HI : LO;
                    else cnt_d = cnt_q - DEAD_WIDTH'(1);
                end
            endcase
            if (enter) begin
                state_d = dt_zero ? (raw_q ? HI : LO) : DEAD;
                tgt_d   = raw_q;
                cnt_d   = dt_zero ? '0 : dead_time - DEAD_WIDTH'(1);
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OFF;
            pend_q  <= '0;
            act_q   <= '0;
            full_q  <= 1'b0;
            raw_q   <= 1'b0;
            tgt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            full_q  <= full_d;
            raw_q   <= raw_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
